// File: rtl/mandel_mem_pkg.sv
// Memory-side constants shared by the Mandelbrot pipeline stages that talk to the MCB:
// instruction codes, DDR buffer bases, burst limit, per-resolution pixel counts.
package mandel_mem_pkg;

    localparam logic [2:0]  MCB_WR    = 3'b000;
    localparam logic [2:0]  MCB_RD    = 3'b001;

    localparam logic [29:0] ITER_BASE = 30'd0;
    localparam logic [29:0] FB_BASE   = 30'd5242880;

    localparam int          MAX_BURST = 64;

    // Frame sizes agreed with the colour stage; 1280x1024 is the largest supported.
    localparam logic [20:0] PIX_VGA   = 21'd307200;
    localparam logic [20:0] PIX_SVGA  = 21'd480000;
    localparam logic [20:0] PIX_XGA   = 21'd786432;
    localparam logic [20:0] PIX_SXGA  = 21'd1310720;

    // Words in the next burst: whatever is left of the frame, capped at the burst limit.
    function automatic logic [6:0] burst_words(input logic [20:0] remaining,
                                               input int unsigned max_burst);
        logic [20:0] cap;
        cap = 21'(max_burst);
        if (remaining >= cap) begin
            return 7'(max_burst);
        end
        return remaining[6:0];
    endfunction

endpackage

// File: rtl/iter_burst_writer_if.sv
// Iteration-word stream in, MCB write/command port out.
// master = the burst writer, slave = the engine/MCB side.
interface iter_burst_writer_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_empty;

    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;

    modport master (
        input  in_valid, in_data, wr_full, wr_empty, cmd_full,
        output in_ready, wr_en, wr_data, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr
    );

    modport slave (
        output in_valid, in_data, wr_full, wr_empty, cmd_full,
        input  in_ready, wr_en, wr_data, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr
    );

endinterface

// File: rtl/iter_burst_writer_synchro.sv
// Two-flop synchroniser for a slow level signal crossing into clk.
module synchro (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/iter_burst_writer.sv
// Packs the engine's raster-order iteration counts into MCB write bursts
// (one 32-bit word per pixel at BASE_ADDR + 4*pixel) for the colour stage.
module iter_burst_writer
    import mandel_mem_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = ITER_BASE,
    parameter int          BURST     = MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_calib_done,
    input  logic                  frame_start,
    input  logic [20:0]           total_pixels,
    iter_burst_writer_if.master   bus,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [2:0] ST_CAL  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_CMD  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic        cal_s;

    logic [2:0]  state_q, state_d;
    logic [20:0] pixel_ptr_q, pixel_ptr_d;
    logic [20:0] tot_q, tot_d;
    logic [6:0]  beat_cnt_q, beat_cnt_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        cmd_en_q, cmd_en_d;
    logic [5:0]  cmd_bl_q, cmd_bl_d;
    logic [29:0] cmd_addr_q, cmd_addr_d;

    logic [6:0]  blen;
    logic [20:0] ptr_next;
    logic        in_ready_c;
    logic        accept;

    synchro u_cal_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mem_calib_done),
        .q     (cal_s)
    );

    // pixel_ptr and tot only move outside FILL/CMD, so blen is constant across a burst.
    assign blen       = burst_words(tot_q - pixel_ptr_q, BURST);
    assign ptr_next   = pixel_ptr_q + 21'(blen);
    assign in_ready_c = (state_q == ST_FILL) && !bus.wr_full && (beat_cnt_q < blen);
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        state_d      = state_q;
        pixel_ptr_d  = pixel_ptr_q;
        tot_d        = tot_q;
        beat_cnt_d   = beat_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        cmd_en_d     = 1'b0;
        cmd_bl_d     = cmd_bl_q;
        cmd_addr_d   = cmd_addr_q;

        case (state_q)
            ST_CAL: begin
                if (cal_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (frame_start) begin
                    tot_d       = total_pixels;
                    busy_d      = 1'b1;
                    pixel_ptr_d = 21'd0;
                    beat_cnt_d  = 7'd0;
                    state_d     = (total_pixels == 21'd0) ? ST_DONE : ST_FILL;
                end
            end

            ST_FILL: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 7'd1;
                end
                if (beat_cnt_q == blen) begin
                    state_d = ST_CMD;
                end
            end

            // Whole burst is already in the write FIFO before the command goes out.
            ST_CMD: begin
                if (!bus.cmd_full) begin
                    cmd_en_d   = 1'b1;
                    cmd_bl_d   = 6'(blen - 7'd1);
                    cmd_addr_d = BASE_ADDR + {7'd0, pixel_ptr_q, 2'b00};
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.wr_empty) begin
                    pixel_ptr_d = ptr_next;
                    beat_cnt_d  = 7'd0;
                    state_d     = (ptr_next == tot_q) ? ST_DONE : ST_FILL;
                end
            end

            ST_DONE: begin
                frame_done_d = 1'b1;
                pixel_ptr_d  = 21'd0;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_CAL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CAL;
            pixel_ptr_q  <= 21'd0;
            tot_q        <= 21'd0;
            beat_cnt_q   <= 7'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_en_q     <= 1'b0;
            cmd_bl_q     <= 6'd0;
            cmd_addr_q   <= 30'd0;
        end else begin
            state_q      <= state_d;
            pixel_ptr_q  <= pixel_ptr_d;
            tot_q        <= tot_d;
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cmd_en_q     <= cmd_en_d;
            cmd_bl_q     <= cmd_bl_d;
            cmd_addr_q   <= cmd_addr_d;
        end
    end

    // Data path is a straight wire: the MCB write FIFO is the only buffer.
    assign bus.in_ready      = in_ready_c;
    assign bus.wr_en         = accept;
    assign bus.wr_data       = bus.in_data;
    assign bus.cmd_en        = cmd_en_q;
    assign bus.cmd_instr     = MCB_WR;
    assign bus.cmd_bl        = cmd_bl_q;
    assign bus.cmd_byte_addr = cmd_addr_q;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
